// File: rtl/idli_utx_m.sv
// UART transmit path: assembles EX 4b slices into bytes, buffers them in a
// small FIFO and serialises each byte as an 8N1 frame on the TX pin.
module idli_utx_m #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_ex_gck,
  input  logic       i_ex_rst_n,
  input  logic [3:0] i_utx_data,
  input  logic       i_utx_vld,
  output logic       o_utx_tx,
  output logic       o_utx_full,
  output logic       o_utx_busy,
  output logic       o_utx_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  state_e        state_q, state_d;
  logic          half_q, half_d;
  logic [3:0]    lo_q, lo_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;

  logic          empty;
  logic          push;
  logic          pop;
  logic          push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push    = i_utx_vld & half_q;
  assign pop     = (state_q == ST_IDLE) & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full_q | pop);

  // Slice assembly and FIFO bookkeeping
  always_comb begin
    half_d = half_q ^ i_utx_vld;
    lo_d   = lo_q;
    mem_d  = mem_q;
    if (i_utx_vld && !half_q) begin
      lo_d = i_utx_data;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = {i_utx_data, lo_q};
    end
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d    = ovf_q | (push & ~push_ok);
    full_d   = ((wr_ptr_d - rd_ptr_d) == PW'(FIFO_DEPTH));
  end

  // Frame FSM; tx_d is the line value for the state being entered
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d = mem_q[rd_ptr_q[AW-1:0]];
          baud_d  = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (wr_ptr_d != rd_ptr_d) || (state_d != ST_IDLE);
  end

  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      state_q  <= ST_IDLE;
      half_q   <= 1'b0;
      lo_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      lo_q     <= lo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      tx_q     <= tx_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
    end
  end

  assign o_utx_tx   = tx_q;
  assign o_utx_full = full_q;
  assign o_utx_busy = busy_q;
  assign o_utx_ovf  = ovf_q;

endmodule

// File: tb/tb_idli_utx_m.sv
// Self-checking bench for idli_utx_m: table of slice sequences with their
// expected serial waveforms, plus hand-written reset sequences.
module tb_idli_utx_m;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data  = 4'h0;
  logic       vld   = 1'b0;
  logic       tx;
  logic       full;
  logic       busy;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idli_utx_m #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_ex_gck  (clk),
    .i_ex_rst_n(rst_n),
    .i_utx_data(data),
    .i_utx_vld (vld),
    .o_utx_tx  (tx),
    .o_utx_full(full),
    .o_utx_busy(busy),
    .o_utx_ovf (ovf)
  );

  typedef struct {
    string      name;
    int         ns;
    logic [3:0] sl [12];
    int         gap;
    int         nb;
    logic [7:0] b [6];
    int         full_from;
    int         full_to;
    logic       ovf;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Slices are packed low nibble first; bytes low byte first.
  function automatic vec_t mk(input string name, input int ns, input logic [47:0] slp,
                              input int gap, input int nb, input logic [47:0] bp,
                              input int ff, input int ft, input logic ov);
    vec_t v;
    v.name = name;
    v.ns   = ns;
    for (int i = 0; i < 12; i++) v.sl[i] = slp[4*i +: 4];
    v.gap  = gap;
    v.nb   = nb;
    for (int i = 0; i < 6; i++) v.b[i] = bp[8*i +: 8];
    v.full_from = ff;
    v.full_to   = ft;
    v.ovf       = ov;
    return v;
  endfunction

  // Expected line in cycle k when the first byte is pushed at the end of cycle p.
  function automatic logic exp_tx(input vec_t v, input int p, input int k);
    int t;
    int f;
    int r;
    logic [7:0] byt;
    if (k < p + 2) return 1'b1;
    t = k - (p + 2);
    f = t / FRAME;
    r = t % FRAME;
    if (f >= v.nb) return 1'b1;
    if (r < int'(CPB)) return 1'b0;
    if (r < 9 * int'(CPB)) begin
      byt = v.b[f];
      return byt[(r - int'(CPB)) / int'(CPB)];
    end
    return 1'b1;
  endfunction

  // Called just after a rising edge; one iteration per clock cycle.
  task automatic run_vec(input vec_t v);
    int p;
    int ncyc;
    int tx_err;
    int busy_err;
    int full_err;
    logic ebusy;
    logic efull;
    p        = 2 + v.gap;
    ncyc     = p + 2 + v.nb * FRAME + 10;
    tx_err   = 0;
    busy_err = 0;
    full_err = 0;
    for (int k = 0; k < ncyc; k++) begin
      vld  = 1'b0;
      data = 4'h0;
      for (int j = 0; j < v.ns; j++) begin
        if (k == 1 + j + ((j >= 1) ? v.gap : 0)) begin
          vld  = 1'b1;
          data = v.sl[j];
        end
      end
      @(negedge clk);
      ebusy = (k >= p + 1) && (k <= p + v.nb * FRAME);
      efull = (k >= v.full_from) && (k <= v.full_to);
      if (tx !== exp_tx(v, p, k)) tx_err++;
      if (busy !== ebusy) busy_err++;
      if (full !== efull) full_err++;
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    check({v.name, " tx_wave_bad_cycles"}, tx_err, 0);
    check({v.name, " busy_wave_bad_cycles"}, busy_err, 0);
    check({v.name, " full_wave_bad_cycles"}, full_err, 0);
    check({v.name, " ovf"}, int'(ovf), int'(v.ovf));
  endtask

  task automatic quiet_check(input string name, input int ncyc);
    int bad;
    bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || ovf !== 1'b0) bad++;
    end
    check({name, " idle_bad_cycles"}, bad, 0);
  endtask

  initial begin
    vecs[0] = mk("byte_a5", 2, 48'hA5, 0, 1, 48'hA5, -1, -1, 1'b0);
    vecs[1] = mk("utx16", 4, 48'h4321, 0, 2, 48'h4321, -1, -1, 1'b0);
    vecs[2] = mk("gapped", 2, 48'h0F, 5, 1, 48'h0F, -1, -1, 1'b0);
    vecs[3] = mk("byte_ff", 2, 48'hFF, 0, 1, 48'hFF, -1, -1, 1'b0);
    vecs[4] = mk("byte_00", 2, 48'h00, 0, 1, 48'h00, -1, -1, 1'b0);
    vecs[5] = mk("gap2_c3", 2, 48'hC3, 2, 1, 48'hC3, -1, -1, 1'b0);
    vecs[6] = mk("overflow", 12, 48'hBA98_7654_3210, 0, 5, 48'h0098_7654_3210, 11, 44, 1'b1);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst tx", int'(tx), 1);
    check("rst full", int'(full), 0);
    check("rst busy", int'(busy), 0);
    check("rst ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_check("post_reset", 50);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // Reset in data bit 3 of 0x21 with 0x43 queued and a half byte (0x7) latched
    for (int k = 0; k <= 21; k++) begin
      vld  = (k >= 1 && k <= 5);
      case (k)
        1:       data = 4'h1;
        2:       data = 4'h2;
        3:       data = 4'h3;
        4:       data = 4'h4;
        5:       data = 4'h7;
        default: data = 4'h0;
      endcase
      @(negedge clk);
      if (k < 21) begin
        @(posedge clk);
        #1;
      end
    end
    vld = 1'b0;
    check("mid bit3 tx", int'(tx), 0);
    check("mid busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid rst tx", int'(tx), 1);
    check("mid rst busy", int'(busy), 0);
    check("mid rst full", int'(full), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_check("after_mid_reset", 100);
    @(posedge clk);
    #1;
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
